// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: shared state encoding and defaults for the bit serializer.
package bit_serializer_pkg;
    typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_PARITY} ser_state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word handshake in, serial bit stream out.
interface bit_serializer_if import bit_serializer_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
    logic [WIDTH-1:0] data_i;
    logic valid_i;
    logic ready_o;
    logic bit_o;
    logic bit_valid_o;
    logic busy_o;
    modport master (output data_i, valid_i, input ready_o, bit_o, bit_valid_o, busy_o);
    modport slave (input data_i, valid_i, output ready_o, bit_o, bit_valid_o, busy_o);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial with one-word hold buffer for gap-free streaming.
// Optional trailing even-parity bit per word under `BIT_SERIALIZER_PARITY_EN.
module bit_serializer import bit_serializer_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic clk,
    input logic rst_n,
    bit_serializer_if.slave s
);
    localparam int CW = $clog2(WIDTH + 1);
    ser_state_t state, state_n;
    logic [WIDTH-1:0] sh, sh_n, hold, hold_n;
    logic [CW-1:0] cnt, cnt_n;
    logic hv, hv_n, xfer, last_data, done, sbit;
    assign xfer = s.valid_i && !hv;
    assign last_data = state == SER_SHIFT && cnt == CW'(WIDTH - 1);
    assign sbit = MSB_FIRST ? sh[WIDTH-1] : sh[0];
`ifdef BIT_SERIALIZER_PARITY_EN
    logic par, par_n;
    assign done = state == SER_PARITY;
    assign s.bit_o = state == SER_PARITY ? par : state == SER_SHIFT && sbit;
`else
    assign done = last_data;
    assign s.bit_o = state == SER_SHIFT && sbit;
`endif
    assign s.bit_valid_o = state != SER_IDLE;
    assign s.ready_o = !hv;
    assign s.busy_o = state != SER_IDLE || hv;
    always_comb begin
        state_n = state;
        sh_n = sh;
        cnt_n = cnt;
        hold_n = hold;
        hv_n = hv;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_n = par;
        if (last_data) state_n = SER_PARITY;
`endif
        if (state == SER_SHIFT) begin
            sh_n = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
            cnt_n = cnt + 1'b1;
        end
        // Word boundary: a held word wins over a direct bypass load.
        if (state == SER_IDLE || done) begin
            cnt_n = '0;
            hv_n = 1'b0;
            state_n = hv || xfer ? SER_SHIFT : SER_IDLE;
            sh_n = hv ? hold : xfer ? s.data_i : sh_n;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_n = hv ? ^hold : xfer ? ^s.data_i : par;
`endif
        end else if (xfer) begin
            hold_n = s.data_i;
            hv_n = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= SER_IDLE;
            sh <= '0;
            cnt <= '0;
            hold <= '0;
            hv <= 1'b0;
        end else begin
            state <= state_n;
            sh <= sh_n;
            cnt <= cnt_n;
            hold <= hold_n;
            hv <= hv_n;
        end
`ifdef BIT_SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) par <= 1'b0;
        else par <= par_n;
`endif
endmodule
